seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have parameter PAT_W, default 5, giving the pattern width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the repeat-count width.
REQ-003 The block SHALL have parameter GAP_W, default 3, giving the inter-repetition gap width.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all logic rises on posedge clk.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a transmit request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port req_pattern, input, PAT_W bits: the pattern, sent MSB first.
REQ-009 The block SHALL have port req_repeat, input, CNT_W bits: the pattern is sent req_repeat+1 times.
REQ-010 The block SHALL have port req_gap, input, GAP_W bits: the number of idle cycles between repetitions.
REQ-011 The block SHALL have port ser_out, output, 1 bit: the serial data bit.
REQ-012 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a pattern bit this cycle.
REQ-013 The block SHALL have port match_exp, output, 1 bit: the expected detector hit, aligned with the last bit of a repetition.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the request completes.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, GAP and DONE.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A handshake SHALL occur when req_valid=1 and req_ready=1 on the same posedge.
REQ-018 On a handshake, the block SHALL latch req_pattern, req_repeat and req_gap, and go IDLE->SHIFT.
REQ-019 Latency: ser_valid=1 and ser_out=req_pattern[PAT_W-1] SHALL appear in the cycle after the handshake.
REQ-020 In SHIFT, the block SHALL output one bit per cycle, MSB to LSB, for PAT_W consecutive cycles, with ser_valid=1.
REQ-021 After the LSB, with repetitions remaining and latched gap>0, the block SHALL go SHIFT->GAP for exactly gap cycles, with ser_valid=0 and ser_out=0.
REQ-022 After the LSB, with repetitions remaining and gap=0, the block SHALL start the next MSB in the next cycle (back-to-back, no bubble).
REQ-023 After the LSB of the final repetition, the block SHALL go SHIFT->DONE; DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-024 A request SHALL be accepted in the cycle after DONE at the earliest.
REQ-025 match_exp SHALL be 1 in the cycle carrying the LSB when the latched pattern equals 5'b10110 or 5'b10010 (PAT_W=5 only); otherwise it SHALL be 0.
REQ-026 match_exp SHALL cover in-pattern hits only; cross-repetition overlap hits are not flagged.
REQ-027 Inputs SHALL be ignored while req_ready=0; changes on req_* mid-transfer SHALL NOT affect the latched values.
REQ-028 The repetition counter SHALL be CNT_W bits and count down; req_repeat=all-ones SHALL yield 2^CNT_W repetitions without wrap error.
REQ-029 The gap counter SHALL be GAP_W bits; gap=all-ones SHALL yield 2^GAP_W-1 idle cycles.
REQ-030 When not in SHIFT, ser_out, ser_valid and match_exp SHALL be 0.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 On reset=1 at a posedge, the state SHALL go to IDLE and all counters and the shift register SHALL clear.
REQ-033 During and after reset: req_ready=1 after the reset cycle; ser_out=0, ser_valid=0, match_exp=0, done=0.
REQ-034 A reset mid-SHIFT or mid-GAP SHALL abort the transfer with no done pulse.
REQ-035 Reset SHALL take priority over a simultaneous handshake.

Structure
REQ-036 Package seq_gen_pkg SHALL hold the state enum and the constants PAT_A=5'b10110 and PAT_B=5'b10010.
REQ-037 The parallel-in serial-out shift register SHALL be sub-module seq_piso (load, shift, msb out).
REQ-038 The FSM, counters and match_exp logic SHALL reside in seq_pattern_tx.

Verification
REQ-039 Single send: pattern 10110, repeat 0, gap 0 -> ser_out 1,0,1,1,0 on cycles 1-5 after the handshake; match_exp=1 on cycle 5; done=1 on cycle 6.
REQ-040 Repeat with gap: pattern 10010, repeat 1, gap 2 -> 5 bits, 2 idle cycles with ser_valid=0, 5 bits; match_exp pulses twice; done on cycle 13.
REQ-041 Non-matching pattern: pattern 11100, repeat 2, gap 0 -> 15 contiguous valid bits; match_exp never 1; done on cycle 16.
REQ-042 Busy ignore: req_valid held high with a new pattern during SHIFT -> the new pattern is not sent; req_ready rises only after done.
REQ-043 Mid-operation reset: reset asserted on bit 3 -> next cycle ser_valid=0, done never pulses, req_ready=1.
REQ-044 Loopback: the output feeds the 10110/10010 overlap detector; detector y matches match_exp cycle-for-cycle for gap greater than or equal to 1.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and reference patterns for the serial pattern transmitter.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [4:0] PAT_A = 5'b10110;
    localparam logic [4:0] PAT_B = 5'b10010;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in serial-out shift register; msb is the registered serial bit.
module seq_piso #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clr)        sr_d = '0;
        else if (load)  sr_d = din;
        else if (shift) sr_d = sr_q << 1;
    end

    always_ff @(posedge clk) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Repeats a latched pattern MSB-first with optional idle gaps and flags
// in-pattern detector hits on the LSB cycle.
module seq_pattern_tx
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = 5,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [PAT_W-1:0] req_pattern,
    input  logic [CNT_W-1:0] req_repeat,
    input  logic [GAP_W-1:0] req_gap,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             match_exp,
    output logic             done
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] LAST = BIT_W'(PAT_W - 1);

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               ser_valid_q, match_q, done_q, ready_q;
    logic               sr_clr, sr_load, sr_shift;
    logic [PAT_W-1:0]   sr_din;
    logic               hit_d;

    generate
        if (PAT_W == 5) begin : g_hit
            assign hit_d = (pat_d == PAT_A) || (pat_d == PAT_B);
        end else begin : g_nohit
            assign hit_d = 1'b0;
        end
    endgenerate

    // The first load comes straight from the request; reloads use the latched copy.
    assign sr_din = (state_q == ST_IDLE) ? req_pattern : pat_q;

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        rep_d     = rep_q;
        gap_cnt_d = gap_cnt_q;
        gap_d     = gap_q;
        pat_d     = pat_q;
        sr_clr    = 1'b0;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    pat_d   = req_pattern;
                    rep_d   = req_repeat;
                    gap_d   = req_gap;
                    bit_d   = '0;
                    sr_load = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_q == LAST) begin
                    if (rep_q == '0) begin
                        sr_clr  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rep_d = rep_q - CNT_W'(1);
                        if (gap_q == '0) begin
                            bit_d   = '0;
                            sr_load = 1'b1;
                        end else begin
                            gap_cnt_d = gap_q;
                            sr_clr    = 1'b1;
                            state_d   = ST_GAP;
                        end
                    end
                end else begin
                    bit_d    = bit_q + BIT_W'(1);
                    sr_shift = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    bit_d   = '0;
                    sr_load = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            rep_q       <= '0;
            gap_cnt_q   <= '0;
            gap_q       <= '0;
            pat_q       <= '0;
            ser_valid_q <= 1'b0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            rep_q       <= rep_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_q       <= gap_d;
            pat_q       <= pat_d;
            ser_valid_q <= (state_d == ST_SHIFT);
            match_q     <= (state_d == ST_SHIFT) && (bit_d == LAST) && hit_d;
            done_q      <= (state_d == ST_DONE);
            ready_q     <= (state_d == ST_IDLE);
        end
    end

    seq_piso #(.W(PAT_W)) u_piso (
        .clk   (clk),
        .reset (reset),
        .clr   (sr_clr),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .msb   (ser_out)
    );

    assign ser_valid = ser_valid_q;
    assign match_exp = match_q;
    assign done      = done_q;
    assign req_ready = ready_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus queues expected per-cycle outputs,
// a monitor pops and compares them, and a loopback detector cross-checks match_exp.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_pattern;
    logic [3:0] req_repeat;
    logic [2:0] req_gap;
    logic       ser_out, ser_valid, match_exp, done;

    int checks = 0;
    int errors = 0;

    // Each entry is {req_ready, ser_valid, ser_out, match_exp, done} for one cycle.
    logic [4:0] exp_q[$];
    int         done_q[$];
    logic       lb_en = 1'b0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.PAT_W(5), .CNT_W(4), .GAP_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pattern (req_pattern),
        .req_repeat  (req_repeat),
        .req_gap     (req_gap),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .match_exp   (match_exp),
        .done        (done)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_req(input logic [4:0] pat, input int rep, input int gap);
        logic hit;
        hit = (pat == 5'b10110) || (pat == 5'b10010);
        for (int r = 0; r <= rep; r++) begin
            for (int b = 4; b >= 0; b--)
                exp_q.push_back({1'b0, 1'b1, pat[b], (b == 0) && hit, 1'b0});
            if (r < rep)
                for (int g = 0; g < gap; g++) exp_q.push_back(5'b00000);
        end
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b10000);
    endtask

    // Issue a request from just after a negedge; the handshake happens at the next posedge.
    task automatic start(input logic [4:0] pat, input int rep, input int gap,
                         input int done_cyc, input logic hold);
        req_pattern = pat;
        req_repeat  = 4'(rep);
        req_gap     = 3'(gap);
        req_valid   = 1'b1;
        @(posedge clk);
        push_req(pat, rep, gap);
        done_q.push_back(done_cyc);
        #1;
        if (hold) begin
            req_pattern = 5'b01111;
            req_repeat  = 4'd3;
            req_gap     = 3'd0;
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", (t < 300) ? 1 : 0, 1);
    endtask

    // Monitor plus loopback overlap detector fed from the serial output.
    initial begin : monitor
        int         cyc = 0;
        logic       hs;
        logic [4:0] e;
        logic [4:0] win;
        logic [3:0] hist = '0;
        int         hcnt = 0;
        logic       y;
        forever begin
            @(posedge clk);
            hs = req_valid && req_ready && !reset;
            @(negedge clk);
            cyc = hs ? 1 : cyc + 1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("req_ready", int'(req_ready), int'(e[4]));
                chk("ser_valid", int'(ser_valid), int'(e[3]));
                chk("ser_out",   int'(ser_out),   int'(e[2]));
                chk("match_exp", int'(match_exp), int'(e[1]));
                chk("done",      int'(done),      int'(e[0]));
            end else if (ser_valid || done) begin
                chk("unexpected_activity", int'({ser_valid, done}), 0);
            end
            if (done) begin
                if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
                else                   chk("unexpected_done", 1, 0);
            end
            win = {hist, ser_out};
            y   = ser_valid && (hcnt >= 4) && (win == 5'b10110 || win == 5'b10010);
            if (lb_en) chk("loopback_y", int'(match_exp), int'(y));
            if (ser_valid) begin
                hist = win[3:0];
                hcnt++;
            end else begin
                hist = '0;
                hcnt = 0;
            end
        end
    end

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_pattern = '0;
        req_repeat  = '0;
        req_gap     = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready",     int'(req_ready), 1);
        chk("rst_ser_valid", int'(ser_valid), 0);
        chk("rst_ser_out",   int'(ser_out),   0);
        chk("rst_match",     int'(match_exp), 0);
        chk("rst_done",      int'(done),      0);
        reset = 1'b0;
        @(negedge clk);

        start(5'b10110, 0, 0, 6, 1'b0);
        wait_drain();

        lb_en = 1'b1;
        start(5'b10010, 1, 2, 13, 1'b0);
        wait_drain();
        lb_en = 1'b0;

        start(5'b11100, 2, 0, 16, 1'b0);
        wait_drain();

        // Busy: request kept high with a different pattern until the done cycle.
        lb_en = 1'b1;
        start(5'b01101, 1, 1, 12, 1'b1);
        repeat (12) @(negedge clk);
        req_valid = 1'b0;
        wait_drain();

        start(5'b10010, 1, 7, 18, 1'b0);
        wait_drain();
        lb_en = 1'b0;

        start(5'b10110, 15, 0, 81, 1'b0);
        wait_drain();

        // Reset while bit 3 is on the line aborts without a done pulse.
        start(5'b11111, 0, 0, 6, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        exp_q.delete();
        done_q.delete();
        repeat (4) exp_q.push_back(5'b10000);
        #1 reset = 1'b0;
        wait_drain();

        // Reset wins over a simultaneous handshake.
        reset       = 1'b1;
        req_valid   = 1'b1;
        req_pattern = 5'b10110;
        req_repeat  = '0;
        req_gap     = '0;
        @(posedge clk);
        repeat (3) exp_q.push_back(5'b10000);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        wait_drain();

        start(5'b10110, 0, 0, 6, 1'b0);
        wait_drain();

        repeat (3) @(negedge clk);
        chk("done_queue_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
